// File: rtl/wbu_wb_queue.sv
// Writeback queue: merges EXU/LSU register writes into an in-order FIFO, retires one per
// cycle to the regfile, and tracks in-flight mul/div destinations for RAW hazard stalls.
module wbu_wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exu_wen,
    input  logic [4:0]      exu_waddr,
    input  logic [XLEN-1:0] exu_wdata,
    input  logic            lsu_wen,
    input  logic [4:0]      lsu_waddr,
    input  logic [XLEN-1:0] lsu_wdata,
    input  logic            mdu_issue,
    input  logic [4:0]      mdu_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            in_ready,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            raw_stall
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      q_addr [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr, exu_slot;
    logic [CW-1:0]   count, n_enq;
    logic [31:0]     pending, pending_nxt;
    logic            lsu_v, exu_v, enq_l, enq_e, pop;
    logic [DEPTH-1:0] ent_vld, hit1, hit2;
    logic            haz1, haz2;

    assign in_ready = (count <= CW'(DEPTH - 2));
    assign lsu_v    = lsu_wen && (lsu_waddr != 5'd0);
    assign exu_v    = exu_wen && (exu_waddr != 5'd0);
    assign enq_l    = in_ready && lsu_v;
    assign enq_e    = in_ready && exu_v;
    // LSU takes the first slot when both arrive together
    assign exu_slot = wr_ptr + PW'(enq_l);
    assign n_enq    = CW'(enq_l) + CW'(enq_e);
    assign pop      = (count != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            pending  <= '0;
        end else begin
            count   <= count + n_enq - CW'(pop);
            wr_ptr  <= wr_ptr + PW'(n_enq);
            rf_wen  <= pop;
            pending <= pending_nxt;
            if (pop) begin
                rf_waddr <= q_addr[rd_ptr];
                rf_wdata <= q_data[rd_ptr];
                rd_ptr   <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by count/rd_ptr alone
    always_ff @(posedge clk) begin
        if (enq_l) begin
            q_addr[wr_ptr] <= lsu_waddr;
            q_data[wr_ptr] <= lsu_wdata;
        end
        if (enq_e) begin
            q_addr[exu_slot] <= exu_waddr;
            q_data[exu_slot] <= exu_wdata;
        end
    end

    // Set after clear so a same-cycle issue to the retiring reg stays pending
    always_comb begin
        pending_nxt = pending;
        if (rf_wen) pending_nxt[rf_waddr] = 1'b0;
        if (mdu_issue && (mdu_rd != 5'd0)) pending_nxt[mdu_rd] = 1'b1;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        assign off        = PW'(i) - rd_ptr;
        assign ent_vld[i] = (CW'(off) < count);
        assign hit1[i]    = ent_vld[i] && (q_addr[i] == rs1);
        assign hit2[i]    = ent_vld[i] && (q_addr[i] == rs2);
    end

    assign haz1 = (rs1 != 5'd0) &&
                  (pending[rs1] || (|hit1) || (rf_wen && (rf_waddr == rs1)));
    assign haz2 = (rs2 != 5'd0) &&
                  (pending[rs2] || (|hit2) || (rf_wen && (rf_waddr == rs2)));
    assign raw_stall = haz1 || haz2;

endmodule

// File: tb/tb_wbu_wb_queue.sv
// Directed bench for wbu_wb_queue: retire latency, ordering, backpressure, x0 drop,
// scoreboard stalls and mid-operation reset.
module tb_wbu_wb_queue;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            exu_wen, lsu_wen, mdu_issue;
    logic [4:0]      exu_waddr, lsu_waddr, mdu_rd, rs1, rs2;
    logic [XLEN-1:0] exu_wdata, lsu_wdata;
    logic            in_ready, rf_wen, raw_stall;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    int n_chk = 0;
    int n_bad = 0;

    wbu_wb_queue #(.DEPTH(4), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .exu_wen(exu_wen), .exu_waddr(exu_waddr), .exu_wdata(exu_wdata),
        .lsu_wen(lsu_wen), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
        .mdu_issue(mdu_issue), .mdu_rd(mdu_rd), .rs1(rs1), .rs2(rs2),
        .in_ready(in_ready), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .raw_stall(raw_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exu_wen = 0; lsu_wen = 0; mdu_issue = 0;
        exu_waddr = 0; lsu_waddr = 0; mdu_rd = 0;
        exu_wdata = 0; lsu_wdata = 0;
    endtask

    task automatic chk_rf(input string tag, input logic w, input logic [4:0] a,
                          input logic [63:0] d);
        chk({tag, ".wen"}, 64'(rf_wen), 64'(w));
        if (w) begin
            chk({tag, ".addr"}, 64'(rf_waddr), 64'(a));
            chk({tag, ".data"}, rf_wdata, d);
        end
    endtask

    initial begin
        idle();
        rs1 = 0; rs2 = 0;
        rst_n = 0;
        tick(); tick();
        chk("rst.wen", 64'(rf_wen), 0);
        chk("rst.addr", 64'(rf_waddr), 0);
        chk("rst.data", rf_wdata, 0);
        chk("rst.rdy", 64'(in_ready), 1);
        chk("rst.stall", 64'(raw_stall), 0);
        rst_n = 1;

        // 1: single EXU write, one-cycle latency
        exu_wen = 1; exu_waddr = 5; exu_wdata = 64'h1234;
        tick(); idle();
        chk("t1.wen0", 64'(rf_wen), 0);
        rs1 = 5; #1;
        chk("t1.qstall", 64'(raw_stall), 1);
        tick();
        chk_rf("t1.ret", 1, 5, 64'h1234);
        chk("t1.rfstall", 64'(raw_stall), 1);
        tick();
        chk("t1.wen", 64'(rf_wen), 0);
        chk("t1.hold", 64'(rf_waddr), 5);
        chk("t1.nostall", 64'(raw_stall), 0);
        rs1 = 0;

        // 2: simultaneous LSU+EXU, LSU first
        lsu_wen = 1; lsu_waddr = 3; lsu_wdata = 64'hAA;
        exu_wen = 1; exu_waddr = 4; exu_wdata = 64'hBB;
        tick(); idle();
        chk("t2.rdy", 64'(in_ready), 1);
        tick(); chk_rf("t2.a", 1, 3, 64'hAA);
        tick(); chk_rf("t2.b", 1, 4, 64'hBB);
        tick(); chk("t2.end", 64'(rf_wen), 0);

        // 3: x0 write dropped
        exu_wen = 1; exu_waddr = 0; exu_wdata = 64'h55;
        tick(); idle();
        chk("t3.wen0", 64'(rf_wen), 0);
        tick();
        chk("t3.wen1", 64'(rf_wen), 0);
        chk("t3.rdy", 64'(in_ready), 1);

        // 4: back-to-back dual writes, backpressure, held request
        lsu_wen = 1; lsu_waddr = 10; lsu_wdata = 64'h1;
        exu_wen = 1; exu_waddr = 11; exu_wdata = 64'h2;
        tick();
        lsu_waddr = 12; lsu_wdata = 64'h3;
        exu_waddr = 13; exu_wdata = 64'h4;
        tick();
        chk("t4.rdy0", 64'(in_ready), 0);
        chk_rf("t4.r0", 1, 10, 64'h1);
        lsu_waddr = 14; lsu_wdata = 64'h5;
        exu_waddr = 15; exu_wdata = 64'h6;
        tick();
        chk_rf("t4.r1", 1, 11, 64'h2);
        chk("t4.rdy1", 64'(in_ready), 1);
        tick(); idle();
        chk_rf("t4.r2", 1, 12, 64'h3);
        chk("t4.rdy2", 64'(in_ready), 0);
        tick(); chk_rf("t4.r3", 1, 13, 64'h4);
        tick(); chk_rf("t4.r4", 1, 14, 64'h5);
        tick(); chk_rf("t4.r5", 1, 15, 64'h6);
        tick(); chk("t4.end", 64'(rf_wen), 0);
        chk("t4.rdy3", 64'(in_ready), 1);

        // 5: scoreboard
        mdu_issue = 1; mdu_rd = 7;
        tick(); idle();
        rs1 = 7; #1;
        chk("t5.pend", 64'(raw_stall), 1);
        tick();
        chk("t5.pend2", 64'(raw_stall), 1);
        exu_wen = 1; exu_waddr = 7; exu_wdata = 64'h77;
        tick(); idle();
        chk("t5.q", 64'(raw_stall), 1);
        tick();
        chk_rf("t5.ret", 1, 7, 64'h77);
        chk("t5.rf", 64'(raw_stall), 1);
        tick();
        chk("t5.clr", 64'(raw_stall), 0);
        mdu_issue = 1; mdu_rd = 9;
        tick(); idle();
        rs1 = 0; rs2 = 0; #1;
        chk("t5.x0", 64'(raw_stall), 0);
        rs2 = 9; #1;
        chk("t5.rs2", 64'(raw_stall), 1);
        rs2 = 0;

        // 6: reset with 3 queued entries
        lsu_wen = 1; lsu_waddr = 20; lsu_wdata = 64'h20;
        exu_wen = 1; exu_waddr = 21; exu_wdata = 64'h21;
        tick();
        lsu_waddr = 22; lsu_wdata = 64'h22;
        exu_waddr = 23; exu_wdata = 64'h23;
        tick(); idle();
        chk("t6.rdy0", 64'(in_ready), 0);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("t6.wen", 64'(rf_wen), 0);
        chk("t6.addr", 64'(rf_waddr), 0);
        chk("t6.rdy", 64'(in_ready), 1);
        rs1 = 21; rs2 = 9; #1;
        chk("t6.stall", 64'(raw_stall), 0);
        rs1 = 0; rs2 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6.drop", 64'(rf_wen), 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running exp=done");
        $fatal(1, "timeout");
    end
endmodule
